// File: rtl/tage_pkg.sv
// Package: tage_pkg
// Types and constants shared by the TAGE predictor blocks: table count,
// use_alt_on_new counter width, allocation LFSR seed, the prediction-counter
// weak values shared with tage_table, and the update-controller state enum.
package tage_pkg;

    localparam int         TAGE_NUM_TABLES = 4;
    localparam int         TAGE_USE_ALT_W  = 4;
    localparam logic [7:0] TAGE_LFSR_SEED  = 8'hA5;

    // Prediction counter in tage_table: a freshly allocated entry is set weak
    // in the direction of the resolved branch.
    localparam int                    TAGE_CTR_W       = 3;
    localparam logic [TAGE_CTR_W-1:0] TAGE_CTR_WEAK_T  = 3'b100;
    localparam logic [TAGE_CTR_W-1:0] TAGE_CTR_WEAK_NT = 3'b011;

    typedef enum logic [1:0] {
        TAGE_IDLE    = 2'd0,
        TAGE_LOOKUP  = 2'd1,
        TAGE_PREDICT = 2'd2,
        TAGE_UPDATE  = 2'd3
    } tage_ctrl_e;

endpackage

// File: rtl/tage_lfsr.sv
// Module: tage_lfsr
// Fibonacci LFSR, shifting toward the MSB with the feedback bit entering at
// bit 0. TAPS marks the register bits XORed into the feedback; the default
// 8'hB8 realises x^8+x^6+x^5+x^4+1. Advances only when en_i is high.
// Ports:
//   clk_i  in   clock
//   rst_i  in   synchronous active-high reset, loads SEED (must be nonzero)
//   en_i   in   advance one step this cycle
//   bit_o  out  current bit 0 of the register
module tage_lfsr #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = 'hA5,
    parameter logic [WIDTH-1:0] TAPS  = 'hB8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic bit_o
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q <= SEED;
        end else if (en_i) begin
            q <= {q[WIDTH-2:0], ^(q & TAPS)};
        end
    end

    assign bit_o = q[0];

endmodule

// File: rtl/tage_update_ctrl.sv
// Module: tage_update_ctrl
// Sequencing controller for the tagged TAGE tables plus base predictor.
// Flow: IDLE accepts a lookup, LOOKUP waits for the tables' registered
// outputs, PREDICT selects provider/altpred and presents the prediction until
// the branch outcome arrives, UPDATE drives one cycle of per-table strobes.
// New lookups are held off until UPDATE completes so every table's prev_idx
// still names the entry that made the prediction.
//
// Handshake: a request transfers on a cycle where req_valid_i && req_ready_o;
// req_ready_o is high only in IDLE and upstream holds the hash inputs while it
// is low. br_valid_i is looked at only in PREDICT and transfers the outcome
// in that cycle; it is ignored in every other state.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   req_valid_i/req_ready_o  lookup request handshake
//   base_pred_i       base predictor output (valid in PREDICT)
//   tag_hit_i, pred_i, new_entry_i, u_i  per-table outputs, bit i = table i
//   pred_valid_o, prediction_o  final prediction (valid in PREDICT)
//   br_valid_i, br_result_i     resolved branch outcome
//   br_result_o       registered outcome fed to all tables
//   provider_o, update_u_o, dec_u_o, alloc_o  one-cycle UPDATE strobes
//   state_o           current controller state (observability)
module tage_update_ctrl
    import tage_pkg::*;
#(
    parameter int         NUM_TABLES = TAGE_NUM_TABLES,
    parameter int         USE_ALT_W  = TAGE_USE_ALT_W,
    parameter logic [7:0] LFSR_SEED  = TAGE_LFSR_SEED
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    base_pred_i,
    input  logic [NUM_TABLES-1:0]   tag_hit_i,
    input  logic [NUM_TABLES-1:0]   pred_i,
    input  logic [NUM_TABLES-1:0]   new_entry_i,
    input  logic [2*NUM_TABLES-1:0] u_i,
    output logic                    pred_valid_o,
    output logic                    prediction_o,
    input  logic                    br_valid_i,
    input  logic                    br_result_i,
    output logic                    br_result_o,
    output logic [NUM_TABLES-1:0]   provider_o,
    output logic [NUM_TABLES-1:0]   update_u_o,
    output logic [NUM_TABLES-1:0]   dec_u_o,
    output logic [NUM_TABLES-1:0]   alloc_o,
    output tage_ctrl_e              state_o
);

    localparam int IW = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1;
    localparam logic [USE_ALT_W-1:0] USE_ALT_INIT = USE_ALT_W'(1) << (USE_ALT_W - 1);
    localparam logic [USE_ALT_W-1:0] USE_ALT_MAX  = '1;

    // {found, index} of the highest hitting table.
    function automatic logic [IW:0] find_provider(input logic [NUM_TABLES-1:0] hits);
        logic [IW:0] r;
        r = '0;
        for (int i = 0; i < NUM_TABLES; i++) begin
            if (hits[i]) r = {1'b1, IW'(i)};
        end
        return r;
    endfunction

    // {found, index} of the highest hitting table strictly below prov.
    function automatic logic [IW:0] find_alt(input logic [NUM_TABLES-1:0] hits,
                                             input logic [IW-1:0]       prov);
        logic [IW:0] r;
        r = '0;
        for (int i = 0; i < NUM_TABLES; i++) begin
            if (hits[i] && (i < int'(prov))) r = {1'b1, IW'(i)};
        end
        return r;
    endfunction

    // One-hot of the lowest candidate, or of the second-lowest when asked
    // and one exists.
    function automatic logic [NUM_TABLES-1:0] pick_alloc(input logic [NUM_TABLES-1:0] cand,
                                                         input logic                  take_second);
        logic [NUM_TABLES-1:0] first;
        logic [NUM_TABLES-1:0] second;
        logic                  seen1;
        logic                  seen2;
        first  = '0;
        second = '0;
        seen1  = 1'b0;
        seen2  = 1'b0;
        for (int i = 0; i < NUM_TABLES; i++) begin
            if (cand[i]) begin
                if (!seen1) begin
                    first[i] = 1'b1;
                    seen1    = 1'b1;
                end else if (!seen2) begin
                    second[i] = 1'b1;
                    seen2     = 1'b1;
                end
            end
        end
        return (take_second && seen2) ? second : first;
    endfunction

    tage_ctrl_e state_q;
    tage_ctrl_e state_d;

    logic [USE_ALT_W-1:0] use_alt_q;
    logic                 lfsr_bit;
    logic                 lfsr_adv;

    // Prediction-side signals, derived from the current table outputs.
    logic [IW:0]           prov_r;
    logic [IW:0]           alt_r;
    logic                  have_prov;
    logic [IW-1:0]         prov_idx;
    logic                  have_alt;
    logic [IW-1:0]         alt_idx;
    logic                  prov_pred;
    logic                  alt_pred;
    logic                  final_pred;
    logic [NUM_TABLES-1:0] above;
    logic [NUM_TABLES-1:0] u_zero;

    // Snapshot taken when the outcome is accepted in PREDICT.
    logic                  have_prov_q;
    logic [IW-1:0]         prov_idx_q;
    logic                  prov_pred_q;
    logic                  alt_pred_q;
    logic                  final_q;
    logic                  new_entry_q;
    logic [NUM_TABLES-1:0] above_q;
    logic [NUM_TABLES-1:0] cand_q;
    logic                  br_result_q;

    // Update-side signals, derived only from the snapshot.
    logic                  latch;
    logic [NUM_TABLES-1:0] prov_onehot;
    logic                  mispredict;
    logic                  alloc_ok;
    logic                  use_alt_upd;

    always_comb begin
        above  = '0;
        u_zero = '0;
        prov_r    = find_provider(tag_hit_i);
        have_prov = prov_r[IW];
        prov_idx  = prov_r[IW-1:0];
        alt_r     = find_alt(tag_hit_i, prov_idx);
        have_alt  = have_prov & alt_r[IW];
        alt_idx   = alt_r[IW-1:0];
        prov_pred = have_prov ? pred_i[prov_idx] : base_pred_i;
        alt_pred  = have_alt  ? pred_i[alt_idx]  : base_pred_i;
        // A newly allocated provider is not yet trusted while use_alt leans alt.
        final_pred = (have_prov && new_entry_i[prov_idx] && use_alt_q[USE_ALT_W-1])
                     ? alt_pred : prov_pred;
        for (int i = 0; i < NUM_TABLES; i++) begin
            // With no provider every tagged table is a longer-history candidate.
            above[i]  = !have_prov || (i > int'(prov_idx));
            u_zero[i] = (u_i[2*i +: 2] == 2'b00);
        end
    end

    assign latch       = (state_q == TAGE_PREDICT) && br_valid_i;
    assign prov_onehot = have_prov_q ? (NUM_TABLES'(1) << prov_idx_q) : '0;
    assign mispredict  = (final_q != br_result_q);
    assign alloc_ok    = mispredict && !(have_prov_q && (prov_idx_q == IW'(NUM_TABLES - 1)));
    assign use_alt_upd = have_prov_q && new_entry_q && (prov_pred_q != alt_pred_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= TAGE_IDLE;
            use_alt_q   <= USE_ALT_INIT;
            have_prov_q <= 1'b0;
            prov_idx_q  <= '0;
            prov_pred_q <= 1'b0;
            alt_pred_q  <= 1'b0;
            final_q     <= 1'b0;
            new_entry_q <= 1'b0;
            above_q     <= '0;
            cand_q      <= '0;
            br_result_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                have_prov_q <= have_prov;
                prov_idx_q  <= prov_idx;
                prov_pred_q <= prov_pred;
                alt_pred_q  <= alt_pred;
                final_q     <= final_pred;
                new_entry_q <= have_prov & new_entry_i[prov_idx];
                above_q     <= above;
                cand_q      <= above & u_zero;
                br_result_q <= br_result_i;
            end
            if ((state_q == TAGE_UPDATE) && use_alt_upd) begin
                if (alt_pred_q == br_result_q) begin
                    if (use_alt_q != USE_ALT_MAX) use_alt_q <= use_alt_q + 1'b1;
                end else begin
                    if (use_alt_q != '0) use_alt_q <= use_alt_q - 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        req_ready_o  = 1'b0;
        pred_valid_o = 1'b0;
        provider_o   = '0;
        update_u_o   = '0;
        dec_u_o      = '0;
        alloc_o      = '0;
        lfsr_adv     = 1'b0;
        case (state_q)
            TAGE_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) state_d = TAGE_LOOKUP;
            end
            TAGE_LOOKUP: begin
                state_d = TAGE_PREDICT;
            end
            TAGE_PREDICT: begin
                pred_valid_o = 1'b1;
                if (br_valid_i) state_d = TAGE_UPDATE;
            end
            TAGE_UPDATE: begin
                provider_o = prov_onehot;
                update_u_o = (prov_pred_q != alt_pred_q) ? prov_onehot : '0;
                if (alloc_ok) begin
                    if (cand_q != '0) alloc_o = pick_alloc(cand_q, lfsr_bit);
                    else              dec_u_o = above_q;
                end
                lfsr_adv = 1'b1;
                state_d  = TAGE_IDLE;
            end
            default: state_d = TAGE_IDLE;
        endcase
    end

    assign prediction_o = pred_valid_o & final_pred;
    assign br_result_o  = br_result_q;
    assign state_o      = state_q;

    tage_lfsr #(
        .WIDTH (8),
        .SEED  (LFSR_SEED),
        .TAPS  (8'hB8)
    ) u_lfsr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (lfsr_adv),
        .bit_o (lfsr_bit)
    );

endmodule
